// File: rtl/simd_pkg.sv
// Shared widths and the queued write-back entry for the SIMD ALU's downstream stages.
package simd_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int DATA_W = LANES * LANE_W;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] rd;
    logic              wen;
    logic [LANES-1:0]  lane_m;
    logic              zero;
  } wb_entry_t;

endpackage

// File: rtl/simd_wb_fifo.sv
// In-order circular buffer of write-back entries; exposes every slot so the
// owner can run a forwarding search over the pending writes.
module simd_wb_fifo
  import simd_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        head,
  output logic [CW-1:0]    count,
  output logic [PTR_W-1:0] rd_ptr,
  output wb_entry_t        entries [DEPTH]
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale slots are invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/simd_writeback_stage.sv
// Write-back stage: queues ALU results, retires them in order to the vector
// register file, and offers forwarding, a zero flag and a retired-op count.
module simd_writeback_stage
  import simd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic [LANES-1:0]  in_lane_m,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [LANES-1:0]  rf_lane_be,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] q_rd,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [LANES-1:0]  fwd_lane_m,
  output logic              zero_flag,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  wb_entry_t        in_entry, head;
  wb_entry_t        entries [DEPTH];
  logic [CW-1:0]    count;
  logic [PTR_W-1:0] rd_ptr, slot;
  logic             push, pop, head_valid;

  // Writes to x0 are demoted to non-writing ops at capture time.
  assign in_entry = '{result: in_result, rd: in_rd, wen: in_wen & (in_rd != '0),
                      lane_m: in_lane_m, zero: in_zero};

  assign in_ready   = rst_n & (count != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign head_valid = rst_n & (count != '0);
  assign pop        = head_valid & (~head.wen | rf_ready);

  simd_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (in_entry),
    .head    (head),
    .count   (count),
    .rd_ptr  (rd_ptr),
    .entries (entries)
  );

  assign rf_we      = head_valid & head.wen;
  assign rf_waddr   = head.rd;
  assign rf_wdata   = head.result;
  assign rf_lane_be = head.lane_m;

  // Oldest-to-youngest scan; a later match overrides, so the youngest wins.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    fwd_lane_m = '0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PTR_W'(i);
      if ((CW'(i) < count) && entries[slot].wen && (entries[slot].rd == q_rd)) begin
        fwd_hit    = 1'b1;
        fwd_data   = entries[slot].result;
        fwd_lane_m = entries[slot].lane_m;
      end
    end
    if (!rst_n || q_rd == '0) fwd_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_flag  <= 1'b0;
      retire_cnt <= '0;
    end else if (pop) begin
      zero_flag  <= head.zero;
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_simd_writeback_stage.sv
// Randomized and directed bench for simd_writeback_stage against a queue-based model.
module tb_simd_writeback_stage;
  import simd_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic [ADDR_W-1:0] in_rd;
  logic              in_wen;
  logic [LANES-1:0]  in_lane_m;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [LANES-1:0]  rf_lane_be;
  logic              rf_ready;
  logic [ADDR_W-1:0] q_rd;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [LANES-1:0]  fwd_lane_m;
  logic              zero_flag;
  logic [CNT_W-1:0]  retire_cnt;

  always #5 clk = ~clk;

  simd_writeback_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_zero    (in_zero),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .in_lane_m  (in_lane_m),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_lane_be (rf_lane_be),
    .rf_ready   (rf_ready),
    .q_rd       (q_rd),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .fwd_lane_m (fwd_lane_m),
    .zero_flag  (zero_flag),
    .retire_cnt (retire_cnt)
  );

  // Reference model: a plain queue of pending ops plus flag and counter.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                rd;
    bit                writes;
    logic [LANES-1:0]  mask;
    bit                zero;
  } op_t;

  op_t              mq[$];
  bit               m_zero;
  logic [CNT_W-1:0] m_cnt;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] res, input int rd,
                       input bit wen, input logic [LANES-1:0] m, input bit rdy,
                       input int qr);
    in_valid  = v;
    in_result = res;
    in_zero   = (res[LANE_W-1:0] == '0);
    in_rd     = ADDR_W'(rd);
    in_wen    = wen;
    in_lane_m = m;
    rf_ready  = rdy;
    q_rd      = ADDR_W'(qr);
  endtask

  // Compare all outputs mid-cycle, then advance the model across the rising edge.
  task automatic step();
    bit   exp_ready, exp_we, hit, do_push, do_pop;
    op_t  hit_op, nop;
    @(negedge clk);
    exp_ready = rst_n && (mq.size() < DEPTH);
    exp_we    = rst_n && (mq.size() > 0) && mq[0].writes;
    hit       = 1'b0;
    hit_op    = '{default: '0};
    if (rst_n && q_rd != 0)
      for (int j = mq.size() - 1; j >= 0; j--)
        if (!hit && mq[j].writes && mq[j].rd == int'(q_rd)) begin
          hit    = 1'b1;
          hit_op = mq[j];
        end
    check("in_ready", DATA_W'(in_ready), DATA_W'(exp_ready));
    check("rf_we", DATA_W'(rf_we), DATA_W'(exp_we));
    if (exp_we) begin
      check("rf_waddr", DATA_W'(rf_waddr), DATA_W'(mq[0].rd));
      check("rf_wdata", rf_wdata, mq[0].data);
      check("rf_lane_be", DATA_W'(rf_lane_be), DATA_W'(mq[0].mask));
    end
    check("fwd_hit", DATA_W'(fwd_hit), DATA_W'(hit));
    if (hit) begin
      check("fwd_data", fwd_data, hit_op.data);
      check("fwd_lane_m", DATA_W'(fwd_lane_m), DATA_W'(hit_op.mask));
    end
    check("zero_flag", DATA_W'(zero_flag), DATA_W'(m_zero));
    check("retire_cnt", DATA_W'(retire_cnt), DATA_W'(m_cnt));

    do_push = in_valid && exp_ready;
    do_pop  = rst_n && (mq.size() > 0) && (!mq[0].writes || rf_ready);
    nop     = '{data: in_result, rd: int'(in_rd), writes: in_wen && (in_rd != 0),
                mask: in_lane_m, zero: in_zero};
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_zero = 1'b0;
      m_cnt  = '0;
    end else begin
      if (do_pop) begin
        m_zero = mq[0].zero;
        m_cnt  = m_cnt + 1;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(nop);
    end
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) d[LANE_W-1:0] = '0;
    return d;
  endfunction

  localparam logic [DATA_W-1:0] VAL_A = 128'h0000_00aa_0000_00bb_0000_00cc_0000_00dd;
  localparam logic [DATA_W-1:0] VAL_B = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DATA_W-1:0] VAL_S = 128'h0000_0004_0000_0003_0000_0002_0000_0001;

  initial begin
    logic [CNT_W-1:0] cnt_before;
    m_zero = 1'b0;
    m_cnt  = '0;
    rst_n  = 1'b0;
    drive(1, VAL_A, 3, 1, 4'hF, 1, 0);
    @(posedge clk);
    #1;

    // Reset held with in_valid high.
    for (int i = 0; i < 3; i++) step();

    // Single op retires the cycle after it is pushed.
    rst_n = 1'b1;
    drive(1, VAL_S, 7, 1, 4'hF, 1, 7);
    step();
    check("single_we", DATA_W'(rf_we), DATA_W'(1));
    check("single_addr", DATA_W'(rf_waddr), DATA_W'(7));
    check("single_data", rf_wdata, VAL_S);
    drive(0, '0, 0, 0, 4'h0, 1, 0);
    step();
    check("single_cnt", DATA_W'(retire_cnt), DATA_W'(1));

    // Backpressure: three back-to-back offers into a two-deep queue.
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_data(), 10 + i, 1, 4'(i + 1), 0, 11);
      step();
    end
    check("full_ready", DATA_W'(in_ready), DATA_W'(0));
    drive(0, '0, 0, 0, 4'h0, 1, 0);
    step();
    step();
    step();

    // Forwarding picks the youngest of two writes to the same register.
    drive(1, VAL_A, 5, 1, 4'h3, 0, 5);
    step();
    drive(1, VAL_B, 5, 1, 4'hC, 0, 5);
    step();
    drive(0, '0, 0, 0, 4'h0, 0, 5);
    #1;
    check("fwd_young_hit", DATA_W'(fwd_hit), DATA_W'(1));
    check("fwd_young_data", fwd_data, VAL_B);
    step();
    q_rd = '0;
    step();
    rf_ready = 1'b1;
    step();
    step();

    // x0 write and a non-writing op both retire without a register write.
    cnt_before = m_cnt;
    drive(1, VAL_A, 0, 1, 4'hF, 0, 0);
    step();
    drive(1, VAL_B, 9, 0, 4'hF, 0, 9);
    step();
    drive(0, '0, 0, 0, 4'h0, 0, 0);
    step();
    check("x0_cnt", DATA_W'(retire_cnt), DATA_W'(cnt_before + 2));

    // Empty lane mask still issues the write.
    drive(1, VAL_B, 4, 1, 4'h0, 1, 4);
    step();
    drive(0, '0, 0, 0, 4'h0, 1, 0);
    step();

    // Mid-stream reset of a full, stalled queue, then a fresh op.
    drive(1, VAL_A, 6, 1, 4'hF, 0, 6);
    step();
    step();
    rst_n = 1'b0;
    step();
    check("rst_cnt", DATA_W'(retire_cnt), DATA_W'(0));
    check("rst_zero", DATA_W'(zero_flag), DATA_W'(0));
    rst_n = 1'b1;
    drive(1, VAL_S, 8, 1, 4'h5, 1, 8);
    step();
    drive(0, '0, 0, 0, 4'h0, 1, 0);
    step();
    check("post_rst_cnt", DATA_W'(retire_cnt), DATA_W'(1));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 7),
            $urandom_range(0, 4) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
